// File: rtl/seq_mul_pkg.sv
// Shared types and derived-width helper for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Width of the iteration counter for a given operand width (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done request bus between the ALU issue logic and the sequential multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product, overflow
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with full 2*WIDTH product; done follows edge WIDTH+1 after start,
// start ignored while busy. `SEQ_MUL_EARLY_TERM_EN stops iterating once the remaining multiplier is zero.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);

  localparam int               PW   = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t            state;
  state_t            state_nxt;

  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CNT_W-1:0]  count;
  logic              neg;
  logic              sgn;

  logic [PW-1:0]     product_q;
  logic              overflow_q;
  logic              done_q;

  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH-1:0]  mplier_shr;
  logic              last_step;
  logic [PW-1:0]     result;
  logic              ovf_nxt;

  // Magnitudes of the most negative value still fit in WIDTH unsigned bits.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.signed_mode && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (bus.signed_mode && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  assign mplier_shr = mplier >> 1;

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last_step = (count == LAST) || (mplier_shr == '0);
`else
  assign last_step = (count == LAST);
`endif

  always_comb begin
    result = neg ? -acc : acc;
    if (sgn) ovf_nxt = (result[PW-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
    else     ovf_nxt = (result[PW-1:WIDTH] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mcand is pre-shifted each step, so it always equals the original multiplicand << count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      neg        <= 1'b0;
      sgn        <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            count  <= '0;
            neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sgn    <= bus.signed_mode;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          count  <= count + CNT_W'(1);
        end
        FIX: begin
          product_q  <= result;
          overflow_q <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: driver queues expected results, a negedge monitor checks them on done.
module tb_seq_multiplier;

  localparam int W = 16;

  typedef struct {
    logic [31:0] p;
    logic        ov;
    int          lat;
    int          start_edge;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] p;
    logic        ov;
    int          lat_full;
    int          lat_early;
    bit          poke;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int tests = 0;
  int fails = 0;
  int issued = 0;
  int done_cnt = 0;
  int both_err = 0;

  exp_t q[$];
  exp_t mon_e;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] b, input logic sm);
    logic [15:0] mb;
    int hb;
    mb = (sm && b[15]) ? -b : b;
    hb = 0;
    for (int i = 0; i < 16; i++) if (mb[i]) hb = i;
`ifdef SEQ_MUL_EARLY_TERM_EN
    return hb + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic ref_mul(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         output logic [31:0] p, output logic ov);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    if (sm) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      p  = sa * sb;
      ov = (p[31:16] != {16{p[15]}});
    end else begin
      p  = {16'h0, a} * {16'h0, b};
      ov = (p[31:16] != 16'h0);
    end
  endtask

  // Waits (from a negedge) for an idle DUT, then issues one operation and queues its expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [31:0] p, input logic ov, input int lat, input bit poke);
    exp_t e;
    int guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) begin
      check("idle_timeout", 1, 0);
      return;
    end
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    e.p = p;
    e.ov = ov;
    e.lat = lat;
    e.start_edge = cyc + 1;
    q.push_back(e);
    issued++;
    @(negedge clk);
    if (poke) begin
      bus.a           = ~a;
      bus.b           = 16'h3333;
      bus.signed_mode = ~sm;
      @(negedge clk);
    end
    bus.start       = 1'b0;
    bus.a           = 16'($urandom);
    bus.b           = 16'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy && bus.done) both_err++;
      if (bus.done) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("product", 64'(bus.product), 64'(mon_e.p));
          check("overflow", 64'(bus.overflow), 64'(mon_e.ov));
          check("latency", 64'(cyc - mon_e.start_edge), 64'(mon_e.lat));
        end
      end
    end
  end

  vec_t vecs[$];

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rp;
    logic        rov;
    int          lat;

    vecs = '{
      '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1, 17, 17, 1'b1},
      '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0, 17,  4, 1'b0},
      '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1, 17, 17, 1'b0},
      '{16'h1234, 16'h0000, 1'b0, 32'h00000000, 1'b0, 17,  2, 1'b0},
      '{16'h1234, 16'h0003, 1'b0, 32'h0000369C, 1'b0, 17,  3, 1'b0},
      '{16'h0001, 16'h8000, 1'b0, 32'h00008000, 1'b0, 17, 17, 1'b0},
      '{16'h0007, 16'h0006, 1'b0, 32'h0000002A, 1'b0, 17,  4, 1'b0},
      '{16'h0007, 16'hFFFA, 1'b1, 32'hFFFFFFD6, 1'b0, 17,  4, 1'b0},
      '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 1'b1, 17, 16, 1'b0},
      '{16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 1'b0, 17, 10, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, 17,  2, 1'b0},
      '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b0, 17,  2, 1'b0}
    };

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 0);
    check("reset_done", 64'(bus.done), 0);
    check("reset_product", 64'(bus.product), 0);
    check("reset_overflow", 64'(bus.overflow), 0);

    foreach (vecs[i]) begin
`ifdef SEQ_MUL_EARLY_TERM_EN
      lat = vecs[i].lat_early;
`else
      lat = vecs[i].lat_full;
`endif
      issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, vecs[i].ov, lat, vecs[i].poke);
    end

    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 150; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (n % 10 == 0) rb = 16'h0001 << (n % 16);
        ref_mul(ra, rb, 1'(m), rp, rov);
        issue(ra, rb, 1'(m), rp, rov, exp_latency(rb, 1'(m)), 1'b0);
      end
    end

    // Abort an operation mid-flight: outputs clear asynchronously and no done follows.
    issue(16'h0007, 16'h0006, 1'b0, 32'h0000002A, 1'b0, exp_latency(16'h0006, 1'b0), 1'b0);
    drain();
    while (bus.busy) @(negedge clk);
    bus.a = 16'h0123;
    bus.b = 16'hFFFF;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 0);
    check("abort_done", 64'(bus.done), 0);
    check("abort_product", 64'(bus.product), 0);
    check("abort_overflow", 64'(bus.overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 1'b0, exp_latency(16'h0100, 1'b0), 1'b0);
    drain();

    repeat (20) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(issued));
    check("busy_done_overlap", 64'(both_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
